// File: rtl/video_edge_frame_stats.sv
// Per-frame edge-pixel statistics (count + bounding box) on a Sobel magnitude stream,
// with a one-clock video pass-through that can outline the previous frame's bounding box.
module video_edge_frame_stats #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    COORD_WIDTH = 12,
    parameter int                    CNT_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] OVERLAY_VAL = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bypass,
    input  logic                   overlay_en,
    input  logic [DATA_WIDTH-1:0]  threshold,
    input  logic [DATA_WIDTH-1:0]  di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [DATA_WIDTH-1:0]  do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   stat_valid_o,
    output logic [CNT_WIDTH-1:0]   edge_cnt_o,
    output logic                   bbox_empty_o,
    output logic [COORD_WIDTH-1:0] x_min_o,
    output logic [COORD_WIDTH-1:0] x_max_o,
    output logic [COORD_WIDTH-1:0] y_min_o,
    output logic [COORD_WIDTH-1:0] y_max_o
);

    function automatic logic [COORD_WIDTH-1:0] sat_inc_coord(input logic [COORD_WIDTH-1:0] v);
        return (v == {COORD_WIDTH{1'b1}}) ? v : v + COORD_WIDTH'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [COORD_WIDTH-1:0] x_p0;
    logic [COORD_WIDTH-1:0] y_p0;
    logic [CNT_WIDTH-1:0]   cnt_p0;
    logic [COORD_WIDTH-1:0] acc_xmin_p0;
    logic [COORD_WIDTH-1:0] acc_xmax_p0;
    logic [COORD_WIDTH-1:0] acc_ymin_p0;
    logic [COORD_WIDTH-1:0] acc_ymax_p0;

    logic is_edge;
    logic line_end;
    logic frame_end;
    logic on_col;
    logic on_row;
    logic ovl_hit;

    // de_o/vs_o are the one-cycle-delayed inputs, so they double as the edge-detect history.
    always_comb begin
        is_edge   = de_i && !vs_i && (di_i >= threshold);
        line_end  = de_o && !de_i;
        frame_end = vs_i && !vs_o;
        on_col    = ((x_p0 == x_min_o) || (x_p0 == x_max_o)) &&
                    (y_p0 >= y_min_o) && (y_p0 <= y_max_o);
        on_row    = ((y_p0 == y_min_o) || (y_p0 == y_max_o)) &&
                    (x_p0 >= x_min_o) && (x_p0 <= x_max_o);
        ovl_hit   = !bypass && overlay_en && de_i && !bbox_empty_o && (on_col || on_row);
    end

    // ---- stage p0: raster position and per-frame accumulators ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else begin
            if (de_i)
                x_p0 <= sat_inc_coord(x_p0);
            else if (line_end)
                x_p0 <= '0;

            if (frame_end)
                y_p0 <= '0;
            else if (line_end)
                y_p0 <= sat_inc_coord(y_p0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0      <= '0;
            acc_xmin_p0 <= '1;
            acc_xmax_p0 <= '0;
            acc_ymin_p0 <= '1;
            acc_ymax_p0 <= '0;
        end else if (frame_end) begin
            cnt_p0      <= '0;
            acc_xmin_p0 <= '1;
            acc_xmax_p0 <= '0;
            acc_ymin_p0 <= '1;
            acc_ymax_p0 <= '0;
        end else if (is_edge) begin
            cnt_p0 <= sat_inc_cnt(cnt_p0);
            if (x_p0 < acc_xmin_p0) acc_xmin_p0 <= x_p0;
            if (x_p0 > acc_xmax_p0) acc_xmax_p0 <= x_p0;
            if (y_p0 < acc_ymin_p0) acc_ymin_p0 <= y_p0;
            if (y_p0 > acc_ymax_p0) acc_ymax_p0 <= y_p0;
        end
    end

    // ---- stage p1: delayed video and latched frame statistics ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_o <= '0;
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            do_o <= ovl_hit ? OVERLAY_VAL : di_i;
            de_o <= de_i;
            hs_o <= hs_i;
            vs_o <= vs_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_valid_o <= 1'b0;
            edge_cnt_o   <= '0;
            bbox_empty_o <= 1'b1;
            x_min_o      <= '0;
            x_max_o      <= '0;
            y_min_o      <= '0;
            y_max_o      <= '0;
        end else begin
            stat_valid_o <= frame_end;
            if (frame_end) begin
                edge_cnt_o <= cnt_p0;
                if (cnt_p0 == '0) begin
                    bbox_empty_o <= 1'b1;
                    x_min_o      <= '0;
                    x_max_o      <= '0;
                    y_min_o      <= '0;
                    y_max_o      <= '0;
                end else begin
                    bbox_empty_o <= 1'b0;
                    x_min_o      <= acc_xmin_p0;
                    x_max_o      <= acc_xmax_p0;
                    y_min_o      <= acc_ymin_p0;
                    y_max_o      <= acc_ymax_p0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_edge_frame_stats.sv
// Directed bench: 8x4 frames with hand-computed counts, bounding boxes and overlay pixels.
module tb_video_edge_frame_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        bypass;
    logic        overlay_en;
    logic [7:0]  threshold;
    logic [7:0]  di_i;
    logic        de_i;
    logic        hs_i;
    logic        vs_i;

    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o, stat_valid_o, bbox_empty_o;
    logic [23:0] edge_cnt_o;
    logic [11:0] x_min_o, x_max_o, y_min_o, y_max_o;

    logic [7:0]  s_do;
    logic        s_de, s_hs, s_vs, s_valid, s_empty;
    logic [3:0]  s_cnt;
    logic [11:0] s_xmin, s_xmax, s_ymin, s_ymax;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_edge_frame_stats dut (
        .clk(clk), .rst(rst), .bypass(bypass), .overlay_en(overlay_en),
        .threshold(threshold), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .stat_valid_o(stat_valid_o), .edge_cnt_o(edge_cnt_o), .bbox_empty_o(bbox_empty_o),
        .x_min_o(x_min_o), .x_max_o(x_max_o), .y_min_o(y_min_o), .y_max_o(y_max_o)
    );

    video_edge_frame_stats #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .bypass(bypass), .overlay_en(overlay_en),
        .threshold(threshold), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(s_do), .de_o(s_de), .hs_o(s_hs), .vs_o(s_vs),
        .stat_valid_o(s_valid), .edge_cnt_o(s_cnt), .bbox_empty_o(s_empty),
        .x_min_o(s_xmin), .x_max_o(s_xmax), .y_min_o(s_ymin), .y_max_o(s_ymax)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int mode, input int xx, input int yy);
        case (mode)
            1: return ((xx == 2 && yy == 1) || (xx == 5 && yy == 2)) ? 200 : 0;
            2: return (yy == 0 && xx == 0) ? 100 : ((yy == 0 && xx == 1) ? 99 : 0);
            4: return 7;
            5: return (yy * 8 + xx < 20) ? 200 : 0;
            6: return (xx == 4 && yy == 3) ? 200 : 0;
            default: return 0;
        endcase
    endfunction

    // vchk: 0 no video check, 1 expect pass-through, 2 expect border of box (2,1)-(5,2)
    task automatic frame(input int mode, input int vchk);
        int exp_px;
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                de_i = 1'b1;
                di_i = 8'(pix(mode, xx, yy));
                tick();
                exp_px = pix(mode, xx, yy);
                if (vchk == 2 && ((((xx == 2) || (xx == 5)) && yy >= 1 && yy <= 2) ||
                                  (((yy == 1) || (yy == 2)) && xx >= 2 && xx <= 5)))
                    exp_px = 255;
                if (vchk != 0) begin
                    chk($sformatf("do_o(%0d,%0d)", xx, yy), 64'(do_o), 64'(exp_px));
                    chk("de_o_active", 64'(de_o), 64'd1);
                end
            end
            de_i = 1'b0;
            di_i = 8'd0;
            hs_i = 1'b1;
            tick();
            if (vchk != 0) begin
                chk("de_o_blank", 64'(de_o), 64'd0);
                chk("hs_o", 64'(hs_o), 64'd1);
            end
            hs_i = 1'b0;
            tick();
        end
    endtask

    task automatic frame_end_chk(input string tag, input int cnt, input int empty,
                                 input int x0, input int x1, input int y0, input int y1);
        vs_i = 1'b1;
        tick();
        chk({tag, ".valid"}, 64'(stat_valid_o), 64'd1);
        chk({tag, ".vs_o"}, 64'(vs_o), 64'd1);
        chk({tag, ".cnt"}, 64'(edge_cnt_o), 64'(cnt));
        chk({tag, ".empty"}, 64'(bbox_empty_o), 64'(empty));
        chk({tag, ".bbox"}, {16'd0, x_min_o, x_max_o, y_min_o, y_max_o},
            {16'd0, 12'(x0), 12'(x1), 12'(y0), 12'(y1)});
        tick();
        chk({tag, ".valid_drop"}, 64'(stat_valid_o), 64'd0);
        chk({tag, ".cnt_hold"}, 64'(edge_cnt_o), 64'(cnt));
        vs_i = 1'b0;
        tick();
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".video"}, {52'd0, do_o, de_o, hs_o, vs_o, stat_valid_o}, 64'd0);
        chk({tag, ".cnt"}, 64'(edge_cnt_o), 64'd0);
        chk({tag, ".empty"}, 64'(bbox_empty_o), 64'd1);
        chk({tag, ".bbox"}, {16'd0, x_min_o, x_max_o, y_min_o, y_max_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; bypass = 1'b0; overlay_en = 1'b0; threshold = 8'd16;
        di_i = 8'd0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        #12;
        reset_chk("reset");
        rst = 1'b0;
        tick();

        // bbox and count
        frame(1, 0);
        frame_end_chk("t1", 2, 0, 2, 5, 1, 2);

        // bypass suppresses overlay even with a valid box; stats of all-7 frame are empty
        bypass = 1'b1; overlay_en = 1'b1;
        frame(4, 1);
        frame_end_chk("t4_bypass", 0, 1, 0, 0, 0, 0);

        // empty latched box: overlay enabled but nothing drawn
        bypass = 1'b0;
        frame(1, 1);
        frame_end_chk("t1_again", 2, 0, 2, 5, 1, 2);

        // overlay of previous box
        frame(4, 2);
        frame_end_chk("t4_ovl", 0, 1, 0, 0, 0, 0);

        // threshold boundary
        overlay_en = 1'b0; threshold = 8'd100;
        frame(2, 0);
        frame_end_chk("t2", 1, 0, 0, 0, 0, 0);

        // empty frame
        threshold = 8'd16;
        frame(3, 0);
        frame_end_chk("t3", 0, 1, 0, 0, 0, 0);

        // 20 edges: full-width counter vs 4-bit saturating counter
        frame(5, 0);
        frame_end_chk("t5", 20, 0, 0, 7, 0, 2);
        chk("t5.sat_cnt", 64'(s_cnt), 64'd15);
        chk("t5.sat_empty", 64'(s_empty), 64'd0);

        // establish non-empty stats, then reset in the middle of a line
        frame(1, 0);
        frame_end_chk("t6_pre", 2, 0, 2, 5, 1, 2);
        for (int xx = 0; xx < 3; xx++) begin
            de_i = 1'b1; di_i = 8'd200;
            tick();
        end
        rst = 1'b1;
        #2;
        reset_chk("t6_rst");
        de_i = 1'b0; di_i = 8'd0;
        tick();
        rst = 1'b0;
        tick();
        frame(6, 0);
        frame_end_chk("t6", 1, 0, 4, 4, 3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_edge_frame_stats.md
Name: video_edge_frame_stats

Overview:
Downstream consumer of the Sobel edge-magnitude stream. Counts edge pixels per frame and tracks their bounding box. At each frame end it latches the results to status outputs and pulses a valid strobe. It passes the video through with one clock of delay, and can optionally draw the previous frame's bounding box over the outgoing stream.

Parameters:
DATA_WIDTH, 8, pixel width
COORD_WIDTH, 12, width of x/y counters and bbox outputs
CNT_WIDTH, 24, width of edge-pixel counter
OVERLAY_VAL, 8'hFF (all ones of DATA_WIDTH), pixel value drawn on bbox border

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
bypass  in  1  1: do_o=di_i, overlay disabled (stats still run)
overlay_en  in  1  enable bbox border overlay
threshold  in  DATA_WIDTH  edge pixel when di_i >= threshold
di_i  in  DATA_WIDTH  edge magnitude pixel
de_i  in  1  data enable
hs_i  in  1  hsync
vs_i  in  1  vsync (1 = vertical blanking)
do_o  out  DATA_WIDTH  video out
de_o  out  1  delayed de_i
hs_o  out  1  delayed hs_i
vs_o  out  1  delayed vs_i
stat_valid_o  out  1  one-cycle pulse, stats updated
edge_cnt_o  out  CNT_WIDTH  edge pixels in last frame
bbox_empty_o  out  1  last frame had zero edge pixels
x_min_o  out  COORD_WIDTH  bbox left
x_max_o  out  COORD_WIDTH  bbox right
y_min_o  out  COORD_WIDTH  bbox top
y_max_o  out  COORD_WIDTH  bbox bottom

Behaviour:
- Reset (async, rst=1): all outputs 0 except bbox_empty_o=1. Internally x=y=0, cnt=0, acc_xmin/acc_ymin=all ones, acc_xmax/acc_ymax=0, de/vs edge-detect registers=0.
- Video path latency: 1 clk for do_o, de_o, hs_o, vs_o.
- Coordinates: x = pixel index within the active line, 0-based. It increments on each de_i=1 cycle and clears on a de_i 1→0 transition. y = active line index. It increments on each de_i 1→0 transition and clears at frame end. Both counters saturate at all ones.
- Pixels with vs_i=1 are ignored for stats.
- Edge pixel: de_i=1, vs_i=0, di_i >= threshold (unsigned). An edge pixel increments cnt, saturating at all ones, and updates acc_xmin/acc_xmax/acc_ymin/acc_ymax with the current (x,y).
- Frame end: vs_i 0→1 edge. Next clk: stat_valid_o=1 for exactly one cycle.
  - edge_cnt_o=cnt.
  - If cnt==0: bbox_empty_o=1 and x_min_o/x_max_o/y_min_o/y_max_o=0. Otherwise bbox_empty_o=0 and the bbox outputs take the acc values.
  - Accumulators and y reset to their reset values in the same cycle.
- No vs_i rising edge: outputs hold indefinitely. The first frame after reset is partial and is reported normally.
- Overlay: applies when bypass=0, overlay_en=1, de_i=1 and bbox_empty_o=0. The latched (previous frame) bbox is used. A pixel is on the border if:
  - (x==x_min_o or x==x_max_o) and y_min_o<=y<=y_max_o, or
  - (y==y_min_o or y==y_max_o) and x_min_o<=x<=x_max_o.
  - Border pixel: do_o=OVERLAY_VAL. Otherwise do_o=di_i.
- threshold, overlay_en and bypass are sampled every cycle; changes mid-frame take effect immediately.
- Reset mid-frame: everything returns to reset state. The next vs_i rising edge reports only the pixels seen after reset.

Test Plan:
1. Bbox and count: frame 8x4, threshold=16, di=200 at (2,1) and (5,2), others 0. Then vs rises → stat_valid_o pulses once, edge_cnt_o=2, x_min_o=2, x_max_o=5, y_min_o=1, y_max_o=2, bbox_empty_o=0.
2. Threshold boundary: threshold=100, di=100 at (0,0), di=99 at (1,0). Then vs rises → edge_cnt_o=1, bbox (0,0)-(0,0).
3. Empty frame: all di=0. Then vs rises → edge_cnt_o=0, bbox_empty_o=1, bbox outputs 0.
4. Overlay: after test 1, overlay_en=1, next frame all di=7 → do_o=255 at (2..5,1), (2..5,2), (2,1..2), (5,1..2); all other pixels 7, delayed 1 clk. With bypass=1 → all 7.
5. Saturation: CNT_WIDTH=4, 20 edge pixels in one frame → edge_cnt_o=15.
6. Reset mid-frame: 3 edge pixels, then rst pulse, then 1 edge pixel at (4,3), then vs rises → edge_cnt_o=1, bbox (4,3)-(4,3). During rst all outputs 0 and bbox_empty_o=1.
